// File: rtl/avg_pool_ctrl_pkg.sv
// rtl/avg_pool_ctrl_pkg.sv - state encoding and parameter defaults for the avg_pool sequencer
package avg_pool_ctrl_pkg;

  localparam int WIN_W_DEF   = 8;
  localparam int CNT_W_DEF   = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    FEED = 3'd2,
    WAIT = 3'd3,
    FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/avg_pool_ctrl_wdog.sv
// rtl/avg_pool_ctrl_wdog.sv - cycle counter that flags a pool result overdue in WAIT
module avg_pool_ctrl_wdog
  import avg_pool_ctrl_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt;

  // Count consecutive WAIT cycles; leaving WAIT restarts the count from zero
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires during the TIMEOUT-th consecutive WAIT cycle
  assign expired = en && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/avg_pool_ctrl.sv
// rtl/avg_pool_ctrl.sv - avg_pool job sequencer; AVG_POOL_CTRL_TIMEOUT_EN enables the WAIT watchdog
module avg_pool_ctrl
  import avg_pool_ctrl_pkg::*;
#(
  parameter int WIN_W   = WIN_W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic [WIN_W-1:0] cfg_win_len,
  input  logic [CNT_W-1:0] cfg_num_win,
  output logic             busy,
  output logic             done,
  output logic             err,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             pool_init,
  output logic             pool_enable,
  output logic             pool_in_valid,
  input  logic             pool_out_valid,
  output logic             res_load,
  output logic             m_valid,
  input  logic             m_ready
);

  state_t           state;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] beat_cnt;
  logic [CNT_W-1:0] num_win_q;
  logic [CNT_W-1:0] win_cnt;
  logic             err_q;
  logic             timeout;
  logic             last_beat;
  logic             last_win;

  assign last_beat = (beat_cnt == win_len_q - 1'b1);
  assign last_win  = (win_cnt == num_win_q - 1'b1);

  // Withhold the final beat of a window while the slot is full, so a result never meets a full slot
  assign s_ready       = (state == FEED) && !(last_beat && m_valid);
  assign pool_in_valid = s_valid && s_ready;
  assign res_load      = (state == WAIT) && pool_out_valid;
  assign err           = err_q;

`ifdef AVG_POOL_CTRL_TIMEOUT_EN
  avg_pool_ctrl_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .en      (state == WAIT),
    .expired (timeout)
  );
`else
  // Without the watchdog WAIT never gives up; TIMEOUT has no effect
  assign timeout = 1'b0 & (TIMEOUT != 0);
`endif

  // Job sequencer: state, latched config, counters and registered control strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pool_init   <= 1'b0;
      pool_enable <= 1'b0;
      err_q       <= 1'b0;
      win_len_q   <= '0;
      num_win_q   <= '0;
      beat_cnt    <= '0;
      win_cnt     <= '0;
    end else begin
      done      <= 1'b0;
      pool_init <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_start) begin
            win_len_q <= (cfg_win_len == '0) ? WIN_W'(1) : cfg_win_len;
            num_win_q <= cfg_num_win;
            beat_cnt  <= '0;
            win_cnt   <= '0;
            err_q     <= 1'b0;
            busy      <= 1'b1;
            if (cfg_num_win == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state       <= INIT;
              pool_init   <= 1'b1;
              pool_enable <= 1'b1;
            end
          end
        end
        INIT: begin
          beat_cnt <= '0;
          state    <= FEED;
        end
        FEED: begin
          if (pool_in_valid) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (res_load) begin
            win_cnt <= win_cnt + 1'b1;
            if (last_win) begin
              state       <= FIN;
              done        <= 1'b1;
              pool_enable <= 1'b0;
            end else begin
              state     <= INIT;
              pool_init <= 1'b1;
            end
          end else if (timeout) begin
            state       <= FIN;
            done        <= 1'b1;
            pool_enable <= 1'b0;
            err_q       <= 1'b1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // One-entry result slot; a load in the same cycle as a drain keeps it full
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
    end else if (res_load) begin
      m_valid <= 1'b1;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_avg_pool_ctrl.sv
// tb/tb_avg_pool_ctrl.sv - self-checking bench for avg_pool_ctrl
module tb_avg_pool_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_win_len = '0;
  logic [15:0] cfg_num_win = '0;
  logic        busy, done, err;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        pool_init, pool_enable, pool_in_valid;
  logic        pool_out_valid;
  logic        res_load, m_valid;
  logic        m_ready = 1'b0;

  avg_pool_ctrl #(
    .WIN_W   (8),
    .CNT_W   (16),
    .TIMEOUT (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_start      (cfg_start),
    .cfg_win_len    (cfg_win_len),
    .cfg_num_win    (cfg_num_win),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .pool_init      (pool_init),
    .pool_enable    (pool_enable),
    .pool_in_valid  (pool_in_valid),
    .pool_out_valid (pool_out_valid),
    .res_load       (res_load),
    .m_valid        (m_valid),
    .m_ready        (m_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int len;
    int num;
    int lat;
    int inits;
    int beats;
    int loads;
    int busy_cyc;
  } vec_t;

  vec_t vecs[6];

  int n_checks = 0;
  int n_fail   = 0;
  int n_init, n_beat, n_load, n_done, n_busy, n_drained;
  int cyc = 0;
  int done_cyc, load_cyc, last_beat_cyc;
  int eff_len  = 1;
  int pool_lat = 0;
  int cd = 0;
  int nb = 0;
  int wid = 0;
  int sb[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_init = 0; n_beat = 0; n_load = 0; n_done = 0; n_busy = 0; n_drained = 0;
    done_cyc = 0; load_cyc = 0; last_beat_cyc = 0;
  endtask

  task automatic start_job(input int len, input int num, input int lat);
    eff_len     = (len == 0) ? 1 : len;
    pool_lat    = lat;
    cfg_win_len = len[7:0];
    cfg_num_win = num[15:0];
    cfg_start   = 1'b1;
    step();
    cfg_start   = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int k = 0;
    while (n_done == 0 && k < bound) begin
      step();
      k++;
    end
    check(name, (n_done > 0) ? 1 : 0, 1);
  endtask

  task automatic wait_beats(input int target, input int bound, input string name);
    int k = 0;
    while (n_beat < target && k < bound) begin
      step();
      k++;
    end
    check(name, (n_beat >= target) ? 1 : 0, 1);
  endtask

  // Pool model + monitor: observe on the falling edge, drive pool_out_valid just after the rising edge
  initial begin
    pool_out_valid = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        nb = 0;
        cd = 0;
      end else begin
        if (pool_init) nb = 0;
        if (pool_in_valid) begin
          nb++;
          if (nb == eff_len) begin
            cd = pool_lat;
            last_beat_cyc = cyc;
          end
        end
        n_init += int'(pool_init);
        n_beat += int'(pool_in_valid);
        n_busy += int'(busy);
        if (res_load) begin
          n_load++;
          load_cyc = cyc;
        end
        if (done) begin
          n_done++;
          done_cyc = cyc;
        end
        if (m_valid && m_ready) begin
          check("result_expected", (sb.size() != 0) ? 1 : 0, 1);
          if (sb.size() != 0) void'(sb.pop_front());
          n_drained++;
        end
      end
      @(posedge clk);
      #1;
      if (cd > 0) begin
        cd--;
        pool_out_valid = (cd == 0);
        if (cd == 0) begin
          sb.push_back(wid);
          wid++;
        end
      end else begin
        pool_out_valid = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "bench did not complete");
  end

  initial begin
    vecs[0] = '{len: 4,   num: 2, lat: 3, inits: 2, beats: 8,   loads: 2, busy_cyc: 17};
    vecs[1] = '{len: 3,   num: 0, lat: 3, inits: 0, beats: 0,   loads: 0, busy_cyc: 1};
    vecs[2] = '{len: 1,   num: 3, lat: 1, inits: 3, beats: 3,   loads: 3, busy_cyc: 10};
    vecs[3] = '{len: 0,   num: 2, lat: 2, inits: 2, beats: 2,   loads: 2, busy_cyc: 9};
    vecs[4] = '{len: 5,   num: 1, lat: 4, inits: 1, beats: 5,   loads: 1, busy_cyc: 11};
    vecs[5] = '{len: 255, num: 1, lat: 1, inits: 1, beats: 255, loads: 1, busy_cyc: 258};

    clear_counts();
    repeat (3) step();
    rst = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    @(negedge clk);
    check("reset_outputs",
          int'({busy, done, err, s_ready, pool_init, pool_enable, pool_in_valid, res_load, m_valid}), 0);
    step();

    for (int i = 0; i < 6; i++) begin
      clear_counts();
      start_job(vecs[i].len, vecs[i].num, vecs[i].lat);
      wait_done(700, $sformatf("v%0d_done_seen", i));
      repeat (3) step();
      check($sformatf("v%0d_inits", i), n_init, vecs[i].inits);
      check($sformatf("v%0d_beats", i), n_beat, vecs[i].beats);
      check($sformatf("v%0d_loads", i), n_load, vecs[i].loads);
      check($sformatf("v%0d_dones", i), n_done, 1);
      check($sformatf("v%0d_busy_cycles", i), n_busy, vecs[i].busy_cyc);
      check($sformatf("v%0d_drained", i), n_drained, vecs[i].num);
      check($sformatf("v%0d_sb_empty", i), sb.size(), 0);
      check($sformatf("v%0d_err", i), int'(err), 0);
      if (vecs[i].num > 0)
        check($sformatf("v%0d_done_after_load", i), done_cyc - load_cyc, 1);
    end

    // Backpressure: slot full blocks only the last beat of the next window
    clear_counts();
    m_ready = 1'b0;
    start_job(3, 2, 2);
    wait_beats(5, 100, "bp_reach_5_beats");
    repeat (4) step();
    @(negedge clk);
    check("bp_beats_held", n_beat, 5);
    check("bp_s_ready_low", int'(s_ready), 0);
    check("bp_m_valid_held", int'(m_valid), 1);
    check("bp_loads_mid", n_load, 1);
    step();
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    wait_done(100, "bp_done_seen");
    repeat (2) step();
    check("bp_beats_total", n_beat, 6);
    check("bp_drained_mid", n_drained, 1);
    @(negedge clk);
    check("bp_m_valid_pending", int'(m_valid), 1);
    check("bp_busy_after_done", int'(busy), 0);
    step();
    m_ready = 1'b1;
    repeat (2) step();
    check("bp_drained_all", n_drained, 2);
    check("bp_sb_empty", sb.size(), 0);

    // Start pulse while in FEED must not relatch the job
    clear_counts();
    s_valid = 1'b0;
    start_job(6, 1, 2);
    step();
    cfg_win_len = 8'd2;
    cfg_num_win = 16'd5;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    s_valid = 1'b1;
    wait_done(100, "ign_done_seen");
    repeat (3) step();
    check("ign_inits", n_init, 1);
    check("ign_beats", n_beat, 6);
    check("ign_loads", n_load, 1);
    check("ign_dones", n_done, 1);

    // Reset in WAIT aborts the job without a done pulse
    clear_counts();
    start_job(2, 2, 0);
    wait_beats(2, 50, "rst_reach_wait");
    repeat (2) step();
    @(negedge clk);
    check("rst_busy_in_wait", int'(busy), 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_outputs_zero",
          int'({busy, done, err, s_ready, pool_init, pool_enable, pool_in_valid, res_load, m_valid}), 0);
    repeat (5) step();
    check("rst_no_done", n_done, 0);
    clear_counts();
    start_job(4, 1, 3);
    wait_done(100, "rst_fresh_done_seen");
    repeat (3) step();
    check("rst_fresh_beats", n_beat, 4);
    check("rst_fresh_loads", n_load, 1);
    check("rst_fresh_drained", n_drained, 1);

`ifdef AVG_POOL_CTRL_TIMEOUT_EN
    // Pool never answers: watchdog aborts after 16 WAIT cycles
    clear_counts();
    start_job(2, 1, 0);
    wait_done(100, "to_done_seen");
    repeat (2) step();
    check("to_done_latency", done_cyc - last_beat_cyc, 17);
    check("to_err_set", int'(err), 1);
    check("to_busy_clear", int'(busy), 0);
    check("to_loads", n_load, 0);
    clear_counts();
    start_job(1, 1, 1);
    @(negedge clk);
    check("to_err_cleared", int'(err), 0);
    step();
    wait_done(50, "to_next_done_seen");
    repeat (3) step();
    check("to_next_loads", n_load, 1);
`else
    check("err_tied_low", int'(err), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
